// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst writer: command encodings, FSM states
// and the width of the shared wait counter.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  localparam int WAIT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASK,
    ST_ACT,
    ST_TRCD,
    ST_WRITE,
    ST_TWR,
    ST_PRE,
    ST_TRP
  } state_t;

endpackage

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter shared by every SDRAM timing wait; done is high while
// the count is zero, so a wait loaded with N lasts N+1 cycles.
module sdram_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sdram_burst_writer.sv
// Burst writer for one SDRAM port: requests the bus, opens a row, streams BL-beat
// write bursts from a FWFT FIFO and closes the row on wrap, refresh or completion.
module sdram_burst_writer
  import sdram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int BL     = 4,
  parameter int LEN_W  = 8,
  parameter int TRCD   = 2,
  parameter int TWR    = 2,
  parameter int TRP    = 2
) (
  input  logic                          sclk,
  input  logic                          srst_n,
  input  logic                          wr_trig,
  input  logic [BANK_W+ROW_W+COL_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]              wr_len,
  input  logic                          ref_req,
  input  logic                          wr_grant,
  input  logic [DW-1:0]                 wr_data,
  output logic                          wr_req,
  output logic                          wr_done,
  output logic                          busy,
  output logic                          wr_data_en,
  output logic [3:0]                    sdram_cmd,
  output logic [BANK_W-1:0]             sdram_bank,
  output logic [ROW_W-1:0]              sdram_addr,
  output logic [DW-1:0]                 sdram_data
);

  localparam int AW     = BANK_W + ROW_W + COL_W;
  localparam int BEAT_W = $clog2(BL);

  state_t              state, state_next;
  logic [BANK_W-1:0]   bank, bank_next, open_bank, open_bank_next;
  logic [ROW_W-1:0]    row, row_next;
  logic [COL_W-1:0]    col, col_next;
  logic [COL_W:0]      col_sum;
  logic [LEN_W-1:0]    remaining, remaining_next;
  logic [BEAT_W-1:0]   beat, beat_next;
  logic                wait_load, wait_done, row_closed;
  logic [WAIT_W-1:0]   wait_val;
  logic                done_next, busy_next;
  logic [3:0]          cmd_next;
  logic [BANK_W-1:0]   ba_next;
  logic [ROW_W-1:0]    addr_next;

  sdram_wait_cnt #(.W(WAIT_W)) u_wait (
    .clk      (sclk),
    .rst_n    (srst_n),
    .load     (wait_load),
    .load_val (wait_val),
    .done     (wait_done)
  );

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_next     = state;
    bank_next      = bank;
    row_next       = row;
    col_next       = col;
    remaining_next = remaining;
    open_bank_next = open_bank;
    beat_next      = beat;
    wait_load      = 1'b0;
    wait_val       = '0;
    done_next      = 1'b0;
    busy_next      = busy;
    row_closed     = 1'b0;
    col_sum        = {1'b0, col} + (COL_W+1)'(BL);

    case (state)
      ST_IDLE: begin
        if (wr_trig && wr_len != '0) begin
          bank_next      = wr_addr[AW-1 -: BANK_W];
          row_next       = wr_addr[COL_W +: ROW_W];
          col_next       = wr_addr[COL_W-1:0] & ~COL_W'(BL-1);
          remaining_next = wr_len;
          busy_next      = 1'b1;
          state_next     = ST_ASK;
        end
      end
      ST_ASK: begin
        if (wr_grant) begin
          open_bank_next = bank;
          state_next     = ST_ACT;
        end
      end
      ST_ACT: begin
        beat_next = '0;
        if (TRCD > 1) begin
          wait_load  = 1'b1;
          wait_val   = WAIT_W'(TRCD-2);
          state_next = ST_TRCD;
        end else begin
          state_next = ST_WRITE;
        end
      end
      ST_TRCD: begin
        if (wait_done) begin
          beat_next  = '0;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        beat_next = beat + BEAT_W'(1);
        if (beat == BEAT_W'(BL-1)) begin
          remaining_next = remaining - LEN_W'(1);
          col_next       = col_sum[COL_W-1:0];
          if (col_sum[COL_W]) begin
            row_next = row + ROW_W'(1);
            if (&row) bank_next = bank + BANK_W'(1);
          end
          // Only the burst boundary looks at ref_req, so a burst is never cut short.
          if (remaining_next == '0 || col_sum[COL_W] || ref_req) begin
            if (TWR > 0) begin
              wait_load  = 1'b1;
              wait_val   = WAIT_W'(TWR-1);
              state_next = ST_TWR;
            end else begin
              state_next = ST_PRE;
            end
          end
        end
      end
      ST_TWR: begin
        if (wait_done) state_next = ST_PRE;
      end
      ST_PRE: begin
        if (TRP > 1) begin
          wait_load  = 1'b1;
          wait_val   = WAIT_W'(TRP-2);
          state_next = ST_TRP;
        end else begin
          row_closed = 1'b1;
        end
      end
      ST_TRP: begin
        if (wait_done) row_closed = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    if (row_closed) begin
      if (remaining == '0) begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end else begin
        state_next = ST_ASK;
      end
    end

    // Command outputs are registered, so they are derived from the state being entered.
    cmd_next  = CMD_NOP;
    ba_next   = '0;
    addr_next = '0;
    case (state_next)
      ST_ACT: begin
        cmd_next  = CMD_ACT;
        ba_next   = bank_next;
        addr_next = row_next;
      end
      ST_WRITE: begin
        if (beat_next == '0) begin
          cmd_next  = CMD_WRITE;
          ba_next   = bank_next;
          addr_next = ROW_W'(col_next) & ~(ROW_W'(1) << 10);
        end
      end
      ST_PRE: begin
        cmd_next = CMD_PRE;
        ba_next  = open_bank_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      bank       <= '0;
      row        <= '0;
      col        <= '0;
      remaining  <= '0;
      open_bank  <= '0;
      beat       <= '0;
      wr_done    <= 1'b0;
      busy       <= 1'b0;
      sdram_cmd  <= CMD_NOP;
      sdram_bank <= '0;
      sdram_addr <= '0;
    end else begin
      bank       <= bank_next;
      row        <= row_next;
      col        <= col_next;
      remaining  <= remaining_next;
      open_bank  <= open_bank_next;
      beat       <= beat_next;
      wr_done    <= done_next;
      busy       <= busy_next;
      sdram_cmd  <= cmd_next;
      sdram_bank <= ba_next;
      sdram_addr <= addr_next;
    end
  end

  assign wr_req     = (state == ST_ASK);
  assign wr_data_en = (state == ST_WRITE);
  assign sdram_data = wr_data;

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Randomized bench for sdram_burst_writer: a transaction-level model expands each
// request into the expected per-cycle command/strobe trace and FIFO data order.
module tb_sdram_burst_writer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam int BL = 4, TRCD = 2, TWR = 2, TRP = 2;
  localparam int ASPACE = 1 << 23;
  localparam int FDEPTH = 4096;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic        wr_trig, ref_req, wr_grant;
  logic [22:0] wr_addr;
  logic [7:0]  wr_len;
  logic [15:0] wr_data;
  logic        wr_req, wr_done, busy, wr_data_en;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_bank;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_data;

  sdram_burst_writer dut (
    .sclk       (sclk),
    .srst_n     (srst_n),
    .wr_trig    (wr_trig),
    .wr_addr    (wr_addr),
    .wr_len     (wr_len),
    .ref_req    (ref_req),
    .wr_grant   (wr_grant),
    .wr_data    (wr_data),
    .wr_req     (wr_req),
    .wr_done    (wr_done),
    .busy       (busy),
    .wr_data_en (wr_data_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_bank (sdram_bank),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [11:0] addr;
    bit          req, den, busy, done;
    int          didx;
    bit          grant, rf, trig;
    logic [22:0] taddr;
    logic [7:0]  tlen;
  } cyc_t;

  cyc_t        tq[$];
  logic [15:0] fifo[FDEPTH];
  int          ptr = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [3:0] cmd, input int bank, input int addr,
                              input bit req, input bit den, input bit bsy, input bit dn,
                              input int didx);
    cyc_t c;
    c.cmd = cmd; c.bank = 2'(bank); c.addr = 12'(addr);
    c.req = req; c.den = den; c.busy = bsy; c.done = dn; c.didx = didx;
    c.grant = 1'b0; c.rf = 1'b0; c.trig = 1'b0; c.taddr = '0; c.tlen = '0;
    return c;
  endfunction

  // Outside ASK the grant is noise; while busy, stray start requests must be ignored.
  task automatic pushb(input cyc_t c);
    if (!c.req) c.grant = ($urandom_range(0, 1) == 1);
    if (c.busy) begin
      c.trig  = ($urandom_range(0, 3) == 0);
      c.taddr = 23'($urandom);
      c.tlen  = 8'($urandom);
    end
    tq.push_back(c);
  endtask

  task automatic gen_idle(input int n, input bit zero_trig);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(NOP, 0, 0, 0, 0, 0, 0, 0);
      if (zero_trig) begin
        c.trig = 1'b1; c.tlen = 8'd0; c.taddr = 23'($urandom);
      end
      tq.push_back(c);
    end
  endtask

  // Expected trace of one request; yield_at is the burst index during which a refresh is
  // raised (-1 for none), delay the grant latency in ASK (-1 for random).
  task automatic gen_txn(input int addr, input int len, input int yield_at, input int delay);
    cyc_t c;
    int a, rem, bi, k, d, bank, row, ob;
    bit more, y;
    a = addr & ~(BL - 1); rem = len; bi = 0; k = ptr;
    c = mk(NOP, 0, 0, 0, 0, 0, 0, 0);
    c.trig = 1'b1; c.taddr = 23'(addr); c.tlen = 8'(len);
    tq.push_back(c);
    while (rem > 0) begin
      d = (delay >= 0) ? delay : int'($urandom_range(0, 3));
      for (int j = 0; j <= d; j++) begin
        c = mk(NOP, 0, 0, 1, 0, 1, 0, 0);
        c.grant = (j == d);
        pushb(c);
      end
      bank = a / (1 << 21); row = (a / 512) % 4096; ob = bank;
      pushb(mk(ACT, bank, row, 0, 0, 1, 0, 0));
      for (int j = 0; j < TRCD - 1; j++) pushb(mk(NOP, 0, 0, 0, 0, 1, 0, 0));
      more = 1'b1;
      while (more) begin
        for (int b = 0; b < BL; b++) begin
          c = mk((b == 0) ? WR : NOP, bank, a % 512, 0, 1, 1, 0, k);
          c.rf = (bi == yield_at) && (b > 0);
          k++;
          pushb(c);
        end
        y = (bi == yield_at);
        a = (a + BL) % ASPACE;
        rem--; bi++;
        more = (rem > 0) && (a % 512 != 0) && !y;
      end
      for (int j = 0; j < TWR; j++) pushb(mk(NOP, 0, 0, 0, 0, 1, 0, 0));
      pushb(mk(PRE, ob, 0, 0, 0, 1, 0, 0));
      for (int j = 0; j < TRP - 1; j++) pushb(mk(NOP, 0, 0, 0, 0, 1, 0, 0));
    end
    tq.push_back(mk(NOP, 0, 0, 0, 0, 0, 1, 0));
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic step(input cyc_t c);
    wr_trig = c.trig; wr_addr = c.taddr; wr_len = c.tlen;
    wr_grant = c.grant; ref_req = c.rf;
    wr_data = fifo[ptr % FDEPTH];
    @(negedge sclk);
    check("cmd", 32'(sdram_cmd), 32'(c.cmd));
    check("req_den_busy_done", 32'({wr_req, wr_data_en, busy, wr_done}),
          32'({c.req, c.den, c.busy, c.done}));
    if (c.cmd != NOP) begin
      check("bank", 32'(sdram_bank), 32'(c.bank));
      check("addr", 32'(sdram_addr), 32'(c.addr));
    end
    if (c.den) check("data", 32'(sdram_data), 32'(fifo[c.didx % FDEPTH]));
    if (wr_data_en) ptr++;
    @(posedge sclk);
    #1;
    cyc++;
  endtask

  task automatic run_all();
    cyc_t c;
    while (tq.size() > 0) begin
      c = tq.pop_front();
      step(c);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd"}, 32'(sdram_cmd), 32'(NOP));
    check({tag, "_bank_addr"}, 32'({sdram_bank, sdram_addr}), 32'd0);
    check({tag, "_req_den_busy_done"}, 32'({wr_req, wr_data_en, busy, wr_done}), 32'd0);
  endtask

  initial begin
    cyc_t c;
    int n;
    for (int i = 0; i < FDEPTH; i++) fifo[i] = 16'($urandom);
    srst_n = 1'b0; wr_trig = 1'b0; wr_addr = '0; wr_len = '0;
    ref_req = 1'b0; wr_grant = 1'b0; wr_data = '0;
    repeat (3) @(posedge sclk);
    #1;
    check_reset("reset");
    srst_n = 1'b1;
    gen_idle(3, 1'b0); run_all();

    // V1: row 5, three bursts, grant after two cycles
    gen_txn(5 << 9, 3, -1, 2); run_all(); gen_idle(2, 1'b0); run_all();
    // V2: column wrap forces a row change mid-request
    gen_txn((12'h010 << 9) | 9'h1F8, 4, -1, -1); run_all(); gen_idle(2, 1'b0); run_all();
    // V3: row wrap carries into the bank
    gen_txn((1 << 21) | (12'hFFF << 9) | 9'h1FC, 2, -1, -1); run_all(); gen_idle(2, 1'b0); run_all();
    // V4: refresh during burst 2 of 5
    gen_txn((12'h020 << 9), 5, 1, -1); run_all(); gen_idle(2, 1'b0); run_all();
    // V6: zero-length starts do nothing
    gen_idle(4, 1'b1); run_all();

    // V5: asynchronous reset in the middle of a burst
    gen_txn((12'h033 << 9) | 9'h040, 3, -1, 1);
    n = 0;
    while (tq.size() > 0 && n < 2) begin
      c = tq.pop_front();
      step(c);
      if (c.den) n++;
    end
    tq.delete();
    #2 srst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge sclk);
    #1;
    check_reset("held_reset");
    srst_n = 1'b1;
    gen_idle(2, 1'b0); run_all();
    gen_txn((2 << 21) | (12'h100 << 9) | 9'h008, 2, -1, -1); run_all(); gen_idle(2, 1'b0); run_all();

    // Random requests, including unaligned columns and refresh yields
    for (int t = 0; t < 14; t++) begin
      int len, ya;
      len = int'($urandom_range(1, 10));
      ya  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      if ($urandom_range(0, 3) == 0)
        gen_txn(int'($urandom_range(0, ASPACE - 1)) | 9'h1F0, len, ya, -1);
      else
        gen_txn(int'($urandom_range(0, ASPACE - 1)), len, ya, -1);
      run_all();
      gen_idle(int'($urandom_range(1, 3)), $urandom_range(0, 1) == 1);
      run_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_burst_writer.md
SDRAM_BURST_WRITER -- requirements
Module: sdram_burst_writer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DW, 16, data width.
- ROW_W, 12, row address width.
- COL_W, 9, column width.
- BANK_W, 2, bank width.
- BL, 4, burst length (power of two, at least 2).
- LEN_W, 8, burst-count width.
- TRCD, 2, ACT-to-WRITE cycles.
- TWR, 2, last-beat-to-PRE cycles.
- TRP, 2, PRE-to-next-ACT cycles.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- sclk, in, 1, the single clock.
- srst_n, in, 1, reset: asynchronous, active-low.
- wr_trig, in, 1, start request.
- wr_addr, in, BANK_W+ROW_W+COL_W, start address as {bank,row,col}.
- wr_len, in, LEN_W, number of bursts.
- ref_req, in, 1, refresh pending, writer must yield.
- wr_grant, in, 1, arbiter grant.
- wr_data, in, DW, write data from a first-word-fall-through FIFO.
- wr_req, out, 1, arbiter request.
- wr_done, out, 1, one-cycle completion pulse.
- busy, out, 1, operation in progress.
- wr_data_en, out, 1, data-pop strobe.
- sdram_cmd, out, 4, {cs_n,ras_n,cas_n,we_n}.
- sdram_bank, out, BANK_W, bank.
- sdram_addr, out, ROW_W, address bus.
- sdram_data, out, DW, DQ write data.

Function
REQ-003 The state machine SHALL have these states: IDLE, ASK, ACT, TRCD, WRITE, TWR, PRE, TRP.
REQ-004 In IDLE, wr_trig with wr_len>0 SHALL:
- latch bank, row and col, with the low log2(BL) col bits forced to 0;
- latch remaining=wr_len;
- set busy and go to ASK.
REQ-005 wr_trig with wr_len=0, and wr_trig outside IDLE, SHALL be ignored.
REQ-006 In ASK, wr_req SHALL be 1. The state SHALL go to ACT in the cycle after wr_grant is sampled 1. wr_req SHALL drop with that transition.
REQ-007 ACT SHALL last 1 cycle with sdram_cmd=ACT, sdram_bank=bank and sdram_addr=row. It SHALL then go to TRCD, which holds NOP for TRCD-1 cycles; for TRCD=1, TRCD is skipped.
REQ-008 Each burst SHALL occupy exactly BL cycles in WRITE:
- cycle 0: sdram_cmd=WRITE, sdram_addr={zero-extended col, A10=0}.
- cycles 1..BL-1: sdram_cmd=NOP.
REQ-009 wr_data_en SHALL be 1 in all BL cycles of each burst and 0 at all other times.
REQ-010 sdram_data SHALL equal wr_data combinationally.
REQ-011 At the last cycle of each burst:
- remaining SHALL decrement;
- col SHALL advance by BL, modulo 2^COL_W;
- on col wrap, row SHALL increment;
- on row wrap, bank SHALL increment, modulo 2^BANK_W.
REQ-012 After a burst, WRITE SHALL continue with the next burst back-to-back only if all of these hold: remaining>0, col did not wrap, and ref_req=0. Otherwise the state SHALL go to TWR.
REQ-013 TWR SHALL hold NOP for TWR cycles.
REQ-014 PRE SHALL last 1 cycle with sdram_cmd=PRE, sdram_addr[10]=0, other address bits 0, and sdram_bank = the bank of the just-closed row.
REQ-015 TRP SHALL hold NOP for TRP-1 cycles.
REQ-016 At the end of TRP:
- if remaining=0: pulse wr_done for 1 cycle, clear busy in the same cycle, go to IDLE;
- otherwise: go to ASK and re-request the bus at the updated address.
REQ-017 A refresh yield SHALL not drop data: remaining and the address SHALL reflect only the bursts already completed.
REQ-018 sdram_cmd encodings SHALL be NOP=0111, ACT=0011, WRITE=0100, PRE=0010. sdram_cmd SHALL be NOP in every cycle not named above.
REQ-019 sdram_cmd, sdram_bank and sdram_addr SHALL be registered outputs.
REQ-020 ref_req arriving mid-burst SHALL not truncate that burst.
REQ-021 wr_grant deasserting after the ACT state is entered SHALL be ignored until the next ASK.

Reset
REQ-022 Asserting srst_n low SHALL immediately clear the following, at any state including mid-burst:
- state to IDLE;
- remaining, bank, row and col to 0;
- all timing counters to 0;
- wr_req, wr_done, busy and wr_data_en to 0;
- sdram_cmd to NOP, sdram_bank to 0, sdram_addr to 0.
REQ-023 The first command after release of srst_n SHALL be NOP.

Structure
REQ-024 The shared package sdram_pkg SHALL hold the command encodings and the state enumeration.
REQ-025 The TRCD, TWR and TRP waits SHALL use one reusable sub-module, sdram_wait_cnt: a loadable down-counter with a done flag, instantiated once and reloaded per state.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- V1: wr_addr={0,0x005,0x000}, wr_len=3, grant after 2 cycles -> one ACT row 5, WRITE at col 0/4/8 every 4 cycles, 12 wr_data_en cycles, PRE after 2 NOPs, wr_done 2 cycles later.
- V2: col=0x1F8, wr_len=4 -> bursts at 0x1F8 and 0x1FC; then PRE, ASK, ACT row+1; bursts at cols 0 and 4.
- V3: row=0xFFF, col=0x1FC, bank=1, wr_len=2 -> second ACT uses bank 2, row 0.
- V4: ref_req raised during burst 2 of 5 -> burst 2 completes; TWR, PRE, TRP, then wr_req again; remaining=3; no lost beats (scoreboard of 20 data words).
- V5: srst_n low mid-WRITE -> all outputs at reset values in the same cycle; a new wr_trig after release runs normally.
- V6: wr_len=0 and wr_trig while busy -> no commands issued, no state change.
